// File: rtl/branch_resolve.sv
// Branch resolution for an always-taken fetch: decodes the EX branch outcome,
// raises a fetch redirect on a not-taken branch, and holds a flush window.
module branch_resolve #(
    parameter int Width    = 32,
    parameter int FlushCyc = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [2:0]       ex_funct3,
    input  logic [Width-1:0] ex_pc,
    input  logic             stall,
    input  logic             BrEq,
    input  logic             BrLt,
    output logic             BrUn,
    output logic             redirect_valid,
    output logic [Width-1:0] redirect_pc,
    output logic             flush,
    output logic             illegal_br,
    output logic [31:0]      br_cnt,
    output logic [31:0]      mis_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [2:0]       FcntLoad = 3'(FlushCyc - 1);
    localparam logic [Width-1:0] PcStep   = Width'(4);

    state_t           r_state;
    logic [2:0]       r_fcnt;
    logic             r_redirect_valid;
    logic [Width-1:0] r_redirect_pc;
    logic             r_flush;
    logic             r_illegal_br;
    logic [31:0]      r_br_cnt;
    logic [31:0]      r_mis_cnt;

    state_t           w_state_nxt;
    logic [2:0]       w_fcnt_nxt;
    logic             w_redirect_valid_nxt;
    logic [Width-1:0] w_redirect_pc_nxt;
    logic             w_flush_nxt;
    logic             w_illegal_br_nxt;
    logic [31:0]      w_br_cnt_nxt;
    logic [31:0]      w_mis_cnt_nxt;

    logic             w_resolve;
    logic             w_legal;
    logic             w_taken;
    logic             w_mispredict;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3[2:1] != 2'b01);
    endfunction

    // Taken decode; reserved encodings report taken so they never mispredict.
    function automatic logic f3_taken(input logic [2:0] f3, input logic eq, input logic lt);
        logic t;
        case (f3)
            3'b000:         t = eq;
            3'b001:         t = ~eq;
            3'b100, 3'b110: t = lt;
            3'b101, 3'b111: t = ~lt;
            default:        t = 1'b1;
        endcase
        return t;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    assign BrUn = ex_funct3[1];

    // Resolve qualification and outcome classification.
    always_comb begin
        w_resolve    = ex_valid & ex_is_branch & ~stall & (r_state == ST_IDLE);
        w_legal      = f3_legal(ex_funct3);
        w_taken      = f3_taken(ex_funct3, BrEq, BrLt);
        w_mispredict = w_resolve & w_legal & ~w_taken;
    end

    // Next-state and registered-output computation.
    always_comb begin
        w_state_nxt          = r_state;
        w_fcnt_nxt           = r_fcnt;
        w_redirect_valid_nxt = 1'b0;
        w_redirect_pc_nxt    = r_redirect_pc;
        w_flush_nxt          = r_flush;
        w_illegal_br_nxt     = 1'b0;
        w_br_cnt_nxt         = r_br_cnt;
        w_mis_cnt_nxt        = r_mis_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_mispredict) begin
                    w_state_nxt          = ST_FLUSH;
                    w_fcnt_nxt           = FcntLoad;
                    w_flush_nxt          = 1'b1;
                    w_redirect_valid_nxt = 1'b1;
                    w_redirect_pc_nxt    = ex_pc + PcStep;
                    w_mis_cnt_nxt        = sat_inc(r_mis_cnt);
                end else begin
                    w_flush_nxt          = 1'b0;
                end
                if (w_resolve & w_legal) begin
                    w_br_cnt_nxt         = sat_inc(r_br_cnt);
                end else begin
                    w_br_cnt_nxt         = r_br_cnt;
                end
                if (w_resolve & ~w_legal) begin
                    w_illegal_br_nxt     = 1'b1;
                end else begin
                    w_illegal_br_nxt     = 1'b0;
                end
            end
            // Flush window counts down even while the pipeline is stalled.
            ST_FLUSH: begin
                if (r_fcnt == 3'd0) begin
                    w_state_nxt = ST_IDLE;
                    w_flush_nxt = 1'b0;
                end else begin
                    w_fcnt_nxt  = r_fcnt - 3'd1;
                    w_flush_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_fcnt_nxt  = 3'd0;
                w_flush_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_fcnt           <= 3'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
            r_illegal_br     <= 1'b0;
            r_br_cnt         <= 32'd0;
            r_mis_cnt        <= 32'd0;
        end else begin
            r_state          <= w_state_nxt;
            r_fcnt           <= w_fcnt_nxt;
            r_redirect_valid <= w_redirect_valid_nxt;
            r_redirect_pc    <= w_redirect_pc_nxt;
            r_flush          <= w_flush_nxt;
            r_illegal_br     <= w_illegal_br_nxt;
            r_br_cnt         <= w_br_cnt_nxt;
            r_mis_cnt        <= w_mis_cnt_nxt;
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = r_flush;
    assign illegal_br     = r_illegal_br;
    assign br_cnt         = r_br_cnt;
    assign mis_cnt        = r_mis_cnt;

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
- REQ-001: Parameter Width, default 32, PC/data width.
- REQ-002: Parameter FlushCyc, default 2, flush-hold length in cycles, legal range 1..7.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: rst  input  1  reset, asynchronous, active-high.
- REQ-005: ex_valid  input  1  EX stage holds a valid instruction this cycle.
- REQ-006: ex_is_branch  input  1  EX instruction is a conditional branch.
- REQ-007: ex_funct3  input  3  branch funct3 field.
- REQ-008: ex_pc  input  Width  PC of the EX instruction.
- REQ-009: stall  input  1  pipeline stall; EX contents are frozen.
- REQ-010: BrEq, BrLt  input  1 each  comparator flags for the current EX operands.
- REQ-011: BrUn  output  1  unsigned-compare select driven to the comparator.
- REQ-012: redirect_valid  output  1  one-cycle pulse requesting a fetch redirect.
- REQ-013: redirect_pc  output  Width  redirect target.
- REQ-014: flush  output  1  squash IF/ID contents.
- REQ-015: illegal_br  output  1  one-cycle pulse on a reserved funct3.
- REQ-016: br_cnt, mis_cnt  output  32 each  resolved-branch count and mispredict count.

Function
- REQ-017: BrUn SHALL be combinational: BrUn = ex_funct3[1], with no dependence on state.
- REQ-018: Resolve event = ex_valid & ex_is_branch & ~stall & (state == IDLE).
- REQ-019: Taken decode:
  - 000 → BrEq
  - 001 → ~BrEq
  - 100 and 110 → BrLt
  - 101 and 111 → ~BrLt
  - 010 and 011 → reserved.
- REQ-020: Fetch is always-taken, so a mispredict occurs exactly when a resolve event has legal funct3 and decodes not-taken.
- REQ-021: On a mispredict, the next clock edge SHALL:
  - assert redirect_valid for exactly 1 cycle;
  - set redirect_pc = ex_pc + 4, modulo 2^Width, so wrap at all-ones is allowed;
  - assert flush;
  - enter FLUSH.
- REQ-022: On a reserved funct3, the next clock edge SHALL:
  - pulse illegal_br for 1 cycle;
  - leave redirect_valid, flush, br_cnt and mis_cnt unchanged.
- REQ-023: FSM states are IDLE and FLUSH; the 3-bit counter fcnt loads FlushCyc-1 on entry to FLUSH.
- REQ-024: In FLUSH, flush = 1 and fcnt decrements every cycle regardless of stall; FLUSH returns to IDLE on the edge where fcnt == 0.
- REQ-025: flush is asserted for exactly FlushCyc consecutive cycles after each mispredict.
- REQ-026: While in FLUSH, ex_valid is ignored: squashed instructions SHALL NOT resolve, count, or redirect.
- REQ-027: br_cnt increments by 1 on each resolve event with legal funct3.
- REQ-028: mis_cnt increments by 1 on each mispredict.
- REQ-029: Both counters saturate at 0xFFFF_FFFF and do not wrap.
- REQ-030: With stall = 1 and state IDLE, no resolve occurs and all registered outputs hold their values, except that redirect_valid and illegal_br remain single-cycle pulses.
- REQ-031: A mispredict on the cycle following FLUSH→IDLE SHALL be handled normally, giving back-to-back flush windows with no gap cycle required.
- REQ-032: redirect_pc SHALL hold its last value when redirect_valid = 0.

Reset
- REQ-033: rst = 1 SHALL immediately, without waiting for clk, force:
  - state = IDLE, fcnt = 0;
  - redirect_valid = 0, redirect_pc = 0;
  - flush = 0, illegal_br = 0;
  - br_cnt = 0, mis_cnt = 0.
- REQ-034: Reset asserted mid-FLUSH SHALL abort the flush; flush is 0 in the first cycle after deassertion.
- REQ-035: After rst deasserts, the first resolve event is evaluated on the first rising edge at which it is present.

Verification
- REQ-036: BEQ with ex_pc = 0x100, BrEq = 1 → no redirect, flush = 0, br_cnt = 1, mis_cnt = 0.
- REQ-037: BNE with ex_pc = 0x200, BrEq = 1 → next cycle redirect_valid = 1 and redirect_pc = 0x204; flush high for exactly 2 cycles; mis_cnt = 1; an ex_valid branch during the flush is not counted.
- REQ-038: BLTU (funct3 110) → BrUn = 1; BGE (funct3 101) → BrUn = 0.
- REQ-039: BGEU with BrLt = 1 and ex_pc = 0xFFFF_FFFC → redirect_pc = 0x0000_0000.
- REQ-040: funct3 = 010 → illegal_br pulses for 1 cycle; counters unchanged; no flush.
- REQ-041: Reset scenarios:
  - Assert rst in the second flush cycle → flush drops asynchronously, all counters read 0.
  - Stall = 1 with a mispredicting branch for 3 cycles → no redirect until stall = 0, then exactly one redirect.
